seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display path. It holds a 32-bit display value (8 hex nibbles) and cycles the 3-bit digit select through digits 0..7. For each digit it presents the matching nibble to the existing segment/anode decoder, and it inserts a blanking guard interval between digits to suppress ghosting. New display values arrive through a valid/ready handshake and take effect only at a frame boundary, so a frame never shows a mix of old and new values.

Parameters:
REFRESH_DIV, 100000, ON-phase length per digit in clk cycles (>=1)
GUARD_CYCLES, 16, blanked guard length per digit in clk cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  new display value offered
load_data  input  32  display value; nibble k = load_data[4k+3:4k] shown on digit k
load_ready  output  1  controller can accept a value
digit_en  input  8  per-digit enable, bit k = digit k, sampled live
num  output  4  nibble for the current digit, to decoder number input
sel  output  3  current digit index, to decoder select input
blank  output  1  1 = force all anodes off (decoder-side gating)
frame_tick  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async on rst_n low; all outputs registered):
  - state=S_GUARD, sel=0, num=0, blank=1, frame_tick=0, load_ready=1.
  - Active register=0, pending register empty, phase counter cnt=0.
- FSM, 2 states:
  - S_GUARD: blank=1. Lasts GUARD_CYCLES cycles (cnt 0..GUARD_CYCLES-1), then goes to S_ON with cnt=0.
  - S_ON: blank = ~digit_en[sel] (plus LZB term below). Lasts REFRESH_DIV cycles, then goes to S_GUARD with sel=sel+1 mod 8 (7 wraps to 0).
- Timing: slot = GUARD_CYCLES+REFRESH_DIV cycles; frame = 8 slots. Slot timing is identical whether a digit is enabled or disabled.
- sel and num update together on entry to S_GUARD. num = active[4*sel_next+3 : 4*sel_next] and is stable for the whole slot.
- Frame boundary: the S_ON(7)->S_GUARD(0) transition.
  - If pending is full: active<=pending, pending emptied, in the same edge that loads sel=0. num for digit 0 uses the new value.
  - frame_tick=1 for the first S_GUARD cycle of digit 0 in every frame, except the first frame after reset.
- Handshake:
  - Transfer occurs when load_valid && load_ready at a rising edge.
  - load_ready = ~pending_full. It goes low the cycle after a transfer and returns high the cycle after commit.
  - load_data must be held only while load_valid && !load_ready.
  - Transfer and boundary in the same cycle: the boundary commits the old pending contents (ready was high, so pending was empty → no commit). The new value commits at the next boundary.
- Active register and pending register are never written from any other path.
- rst_n asserted mid-frame: immediate return to reset values. An accepted-but-uncommitted value is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: during S_ON, blank is also 1 for every digit k with k > index of the most-significant nonzero nibble of active.
  - Digit 0 is never blanked by this rule.
  - Active=0 shows only digit 0.
  - Evaluated from the active register, so it changes only at frame boundaries.
- Undefined: blanking depends only on state and digit_en.

Test Plan:
Bench uses REFRESH_DIV=4, GUARD_CYCLES=2 (slot 6 cycles, frame 48).
1. Reset, digit_en=8'hFF, no load -> blank=1 for 2 cycles then 0 for 4; sel steps 0,1,..,7,0 every 6 cycles; num=0 throughout; frame_tick first at cycle 48.
2. load_data=32'h76543210 accepted mid-frame -> load_ready low next cycle; display unchanged until boundary; following frame shows num==sel on each digit; load_ready high one cycle after commit.
3. Second load 32'hFFFFFFFF while pending is full -> load_valid held, no transfer until after commit; 32'h76543210 frame appears first, then the all-F frame one frame later.
4. digit_en=8'b1010_1010 -> blank=1 for the whole slot of digits 0,2,4,6; normal guard/on pattern on 1,3,5,7; slot timing unchanged.
5. rst_n pulsed low at cycle 20 with a pending value -> outputs at reset values asynchronously; after release, scan restarts at sel=0 and num=0 (pending discarded).
6. LEADING_ZERO_BLANK_EN, active=32'h00000305 -> digits 0-2 lit, digits 3-7 blanked in S_ON; active=0 -> only digit 0 lit.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display-value load handshake for the seven-segment scan controller
interface seven_seg_scan_ctrl_if;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 8-digit seven-segment scan controller with guard blanking and frame-aligned loads
// Optional: LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seven_seg_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   seven_seg_scan_ctrl_if.slave        load,
   input  logic [7:0]                  digit_en,
   output logic [3:0]                  num,
   output logic [2:0]                  sel,
   output logic                        blank,
   output logic                        frame_tick
);

   localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic {S_GUARD, S_ON} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    sel_q, sel_d;
   logic [3:0]    num_q, num_d;
   logic          blank_q, blank_d;
   logic          tick_q, tick_d;
   logic          ready_q, ready_d;
   logic [31:0]   active_q, active_d;
   logic [31:0]   pend_q, pend_d;
   logic          boundary;
   logic          lzb_blank;

`ifdef LEADING_ZERO_BLANK_EN
   logic [2:0] msnz;

   always_comb begin
      msnz = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (active_q[4*k +: 4] != 4'd0) msnz = 3'(k);
      end
   end

   // Only consulted for S_ON cycles, where active_q cannot change underneath it.
   assign lzb_blank = (sel_d > msnz);
`else
   assign lzb_blank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_GUARD;
         cnt_q    <= '0;
         sel_q    <= 3'd0;
         num_q    <= 4'd0;
         blank_q  <= 1'b1;
         tick_q   <= 1'b0;
         ready_q  <= 1'b1;
         active_q <= 32'd0;
         pend_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         num_q    <= num_d;
         blank_q  <= blank_d;
         tick_q   <= tick_d;
         ready_q  <= ready_d;
         active_q <= active_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      sel_d    = sel_q;
      num_d    = num_q;
      ready_d  = ready_q;
      active_d = active_q;
      pend_d   = pend_q;
      boundary = 1'b0;

      if (state_q == S_GUARD) begin
         if (cnt_q == G_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
         end
      end else begin
         if (cnt_q == R_LAST) begin
            state_d  = S_GUARD;
            cnt_d    = '0;
            sel_d    = sel_q + 3'd1;
            boundary = (sel_q == 3'd7);
         end
      end

      // Accept and commit are mutually exclusive: accept needs pending empty, commit needs it full.
      if (load.load_valid && ready_q) begin
         pend_d  = load.load_data;
         ready_d = 1'b0;
      end else if (boundary && !ready_q) begin
         active_d = pend_q;
         ready_d  = 1'b1;
      end

      if (state_q == S_ON && state_d == S_GUARD) begin
         num_d = active_d[{sel_d, 2'b00} +: 4];
      end

      tick_d  = boundary;
      blank_d = (state_d == S_GUARD) | ~digit_en[sel_d] | lzb_blank;
   end

   assign num             = num_q;
   assign sel             = sel_q;
   assign blank           = blank_q;
   assign frame_tick      = tick_q;
   assign load.load_ready = ready_q;

endmodule
